game_ctrl: RTL

Top-level game sequencer that owns the run/pause/game-over state machine and schedules the score datapath. It produces the game-state code `gs` and the `halt` flag consumed by the scoring/render blocks. It also generates the score tick, keeps the authoritative 4-digit BCD score and high score, and derives an obstacle speed level. It sits between the button/collision inputs and the VGA-side display blocks.

---
 rtl/game_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/game_ctrl.sv
`default_nettype none
// =============================================================================
// game_ctrl : run/pause/over sequencer, BCD score tick, speed level and an
//             optional high score built when GAME_CTRL_HISCORE_EN is defined.
// Revision  : 1.0
// =============================================================================
module game_ctrl #(
  parameter int TICK_DIV  = 2517500,
  parameter int SPEED_MAX = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        collide,
  output logic [1:0]  gs,
  output logic        halt,
  output logic [15:0] score,
  output logic [15:0] hiscore,
  output logic [2:0]  speed,
  output logic        new_best
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
  localparam logic [2:0]    SPEED_TOP = 3'(SPEED_MAX);
  localparam logic [15:0]   SCORE_SAT = 16'h9999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_OVER  = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [2:0]    start_sr;
  logic [2:0]    pause_sr;
  logic          start_ev;
  logic          pause_ev;
  logic [PW-1:0] presc;
  logic          presc_wrap;
  logic          clear_run;
  logic          run_count;
  logic [15:0]   score_inc;
  logic          inc_carry;
  logic          score_sat;

  // [0],[1] form the synchronizer, [2] holds the previous synchronized level
  always_ff @(posedge clk) begin
    if (reset) begin
      start_sr <= 3'b000;
      pause_sr <= 3'b000;
    end else begin
      start_sr <= {start_sr[1:0], btn_start};
      pause_sr <= {pause_sr[1:0], btn_pause};
    end
  end

  assign start_ev = start_sr[1] & ~start_sr[2];
  assign pause_ev = pause_sr[1] & ~pause_sr[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      halt  <= 1'b1;
    end else begin
      state <= state_nxt;
      halt  <= (state_nxt != ST_RUN);
    end
  end

  assign gs = state;

  // collide beats a pause event, which beats the tick
  always_comb begin
    state_nxt = state;
    clear_run = 1'b0;
    run_count = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start_ev) begin
          state_nxt = ST_RUN;
          clear_run = 1'b1;
        end
      end
      ST_RUN: begin
        if (collide)       state_nxt = ST_OVER;
        else if (pause_ev) state_nxt = ST_PAUSE;
        else               run_count = 1'b1;
      end
      ST_PAUSE: begin
        if (start_ev || pause_ev) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign presc_wrap = (presc == PRESC_TOP);
  assign score_sat  = (score == SCORE_SAT);

  always_comb begin
    score_inc = score;
    inc_carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (inc_carry) begin
        if (score[i*4 +: 4] == 4'd9) begin
          score_inc[i*4 +: 4] = 4'd0;
        end else begin
          score_inc[i*4 +: 4] = score[i*4 +: 4] + 4'd1;
          inc_carry           = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      score <= 16'h0000;
      speed <= 3'd0;
    end else if (clear_run) begin
      presc <= '0;
      score <= 16'h0000;
      speed <= 3'd0;
    end else if (run_count) begin
      if (presc_wrap) begin
        presc <= '0;
        if (!score_sat) begin
          score <= score_inc;
          if ((score[7:0] == 8'h99) && (speed < SPEED_TOP)) speed <= speed + 3'd1;
        end
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

`ifdef GAME_CTRL_HISCORE_EN
  logic game_over;

  assign game_over = (state == ST_RUN) && collide;

  // digits are always valid BCD, so a plain unsigned compare orders them
  always_ff @(posedge clk) begin
    if (reset) begin
      hiscore  <= 16'h0000;
      new_best <= 1'b0;
    end else begin
      new_best <= 1'b0;
      if (game_over && (score > hiscore)) begin
        hiscore  <= score;
        new_best <= 1'b1;
      end
    end
  end
`else
  assign hiscore  = 16'h0000;
  assign new_best = 1'b0;
`endif

endmodule
`default_nettype wire
